// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared RAM geometry and read-return tag types for the data-RAM arbiter and its clients.
package ram_arb_pkg;
    localparam int RAM_ADDR_W = 16;
    localparam int RAM_DATA_W = 16;
    typedef logic port_id_t;
    typedef struct packed {
        logic     valid;
        port_id_t port_id;
    } arb_tag_t;
endpackage

// File: rtl/ram_arb_tag_pipe.sv
// ram_arb_tag_pipe: fixed-depth shift register carrying read-return tags alongside the RAM latency.
module ram_arb_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic     clock,
    input  logic     reset_n,
    input  arb_tag_t tag_in,
    output arb_tag_t pre_tail,
    output arb_tag_t tail
);
    arb_tag_t [DEPTH-1:0] stage;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) stage <= '0;
        else stage <= {stage[DEPTH-2:0], tag_in};
    // pre_tail marks the cycle q_ram is valid; tail marks the rvalid cycle
    assign pre_tail = stage[DEPTH-2];
    assign tail     = stage[DEPTH-1];
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of the single-port data RAM between the core (port 0, lockable) and the I/O engine (port 1).
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W       = RAM_ADDR_W,
    parameter int DATA_W       = RAM_DATA_W,
    parameter int READ_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address_ram,
    output logic [DATA_W-1:0] data_ram,
    output logic              wren_ram,
    input  logic [DATA_W-1:0] q_ram
);
    typedef enum logic {IDLE_RR, LOCKED} lock_state_t;
    lock_state_t state, state_next;
    port_id_t    last_grant;
    arb_tag_t    tag_in, tag_pre, tag_tail;
    logic        lock_owner, grant, grant_we;
    assign lock_owner = (state == LOCKED);
    // a tie goes to the port that did not win last
    always_comb begin
        gnt0       = lock_owner ? req0 : req0 && (!req1 || last_grant);
        gnt1       = lock_owner ? 1'b0 : req1 && (!req0 || !last_grant);
        grant      = gnt0 || gnt1;
        grant_we   = gnt1 ? we1 : we0;
        tag_in     = '{valid: grant && !grant_we, port_id: gnt1};
        state_next = lock_owner ? (lock0 ? LOCKED : IDLE_RR) : ((gnt0 && lock0) ? LOCKED : IDLE_RR);
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state       <= IDLE_RR;
            last_grant  <= 1'b1;
            address_ram <= '0;
            data_ram    <= '0;
            wren_ram    <= 1'b0;
        end else begin
            state    <= state_next;
            wren_ram <= grant && grant_we;
            if (grant) begin
                last_grant  <= gnt1;
                address_ram <= gnt1 ? addr1 : addr0;
                data_ram    <= gnt1 ? wdata1 : wdata0;
            end
        end
    ram_arb_tag_pipe #(.DEPTH(READ_LATENCY + 1)) u_tag_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .tag_in  (tag_in),
        .pre_tail(tag_pre),
        .tail    (tag_tail)
    );
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            if (tag_pre.valid && !tag_pre.port_id) rdata0 <= q_ram;
            if (tag_pre.valid && tag_pre.port_id) rdata1 <= q_ram;
        end
    assign rvalid0 = tag_tail.valid && !tag_tail.port_id;
    assign rvalid1 = tag_tail.valid && tag_tail.port_id;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: drives a latency-2 and a latency-1 arbiter in lockstep against RAM models and a read-return scoreboard.
module tb_ram_port_arbiter;
    localparam int RL_A = 2;
    localparam int RL_B = 1;
    typedef struct {
        logic        port;
        logic [15:0] data;
        int          due;
    } exp_t;
    logic clock, reset_n, req0, we0, lock0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1, q_a, q_b;
    logic [1:0] gnt0, gnt1, rv0, rv1, wren;
    logic [1:0][15:0] rd0, rd1, aram, dram;
    logic [15:0] mem [logic [15:0]];
    logic [15:0] refm [logic [15:0]];
    exp_t sb0[$], sb1[$];
    int checks = 0, errors = 0, cyc = 0;

    ram_port_arbiter #(.READ_LATENCY(RL_A)) u_a (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0[0]), .rvalid0(rv0[0]), .rdata0(rd0[0]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1[0]), .rvalid1(rv1[0]), .rdata1(rd1[0]),
        .address_ram(aram[0]), .data_ram(dram[0]), .wren_ram(wren[0]), .q_ram(q_a)
    );
    ram_port_arbiter #(.READ_LATENCY(RL_B)) u_b (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0[1]), .rvalid0(rv0[1]), .rdata0(rd0[1]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1[1]), .rvalid1(rv1[1]), .rdata1(rd1[1]),
        .address_ram(aram[1]), .data_ram(dram[1]), .wren_ram(wren[1]), .q_ram(q_b)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] iv(input logic [15:0] a);
        return (a == 16'h0012) ? 16'h00AB : a ^ 16'h5A00;
    endfunction

    // write-first RAM: A registers the address once (latency 2), B reads combinationally (latency 1)
    always @(posedge clock) begin
        if (wren[0]) mem[aram[0]] = dram[0];
        q_a <= mem.exists(aram[0]) ? mem[aram[0]] : iv(aram[0]);
        #1 q_b = mem.exists(aram[1]) ? mem[aram[1]] : iv(aram[1]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ret_check(input int d);
        exp_t e;
        bit have;
        have = d ? sb1.size() > 0 : sb0.size() > 0;
        if (have) e = d ? sb1[0] : sb0[0];
        if (rv0[d] || rv1[d]) begin
            if (!have) chk($sformatf("rv_unexpected_%0d", d), {30'd0, rv1[d], rv0[d]}, 0);
            else begin
                if (d) void'(sb1.pop_front()); else void'(sb0.pop_front());
                chk($sformatf("rv_port_%0d", d), {30'd0, rv1[d], rv0[d]}, e.port ? 2 : 1);
                chk($sformatf("rdata_%0d", d), e.port ? rd1[d] : rd0[d], e.data);
                chk($sformatf("rv_latency_%0d", d), cyc, e.due);
            end
        end else if (have && e.due <= cyc) begin
            if (d) void'(sb1.pop_front()); else void'(sb0.pop_front());
            chk($sformatf("rv_missing_%0d", d), {30'd0, rv1[d], rv0[d]}, e.port ? 2 : 1);
        end
    endtask

    // scoreboard: reads are predicted at grant time from a reference memory
    always @(negedge clock) if (reset_n) begin
        logic p, w;
        logic [15:0] a, v;
        ret_check(0);
        ret_check(1);
        chk("lockstep", {gnt1[1], gnt0[1], wren[1], aram[1]}, {gnt1[0], gnt0[0], wren[0], aram[0]});
        if (gnt0[0] || gnt1[0]) begin
            p = gnt1[0];
            w = p ? we1 : we0;
            a = p ? addr1 : addr0;
            if (w) refm[a] = p ? wdata1 : wdata0;
            else begin
                v = refm.exists(a) ? refm[a] : iv(a);
                sb0.push_back('{p, v, cyc + RL_A + 1});
                sb1.push_back('{p, v, cyc + RL_B + 1});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic access(input logic p, input logic we, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        if (p) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        else begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        @(negedge clock);
        while (!(p ? gnt1[0] : gnt0[0]) && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk(p ? "gnt1" : "gnt0", {31'd0, p ? gnt1[0] : gnt0[0]}, 1);
        @(posedge clock);
        #1;
        if (p) req1 = 0; else req0 = 0;
    endtask

    initial begin
        reset_n = 0; req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; lock0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        idle(3);
        chk("rst_addr", aram[0], 0);
        chk("rst_data", {dram[1], dram[0]}, 0);
        chk("rst_wren", {30'd0, wren}, 0);
        chk("rst_rvalid", {28'd0, rv1, rv0}, 0);
        chk("rst_rdata", {rd1[0], rd0[0]}, 0);
        reset_n = 1;
        idle(1);
        // first access: single port 0 read
        access(0, 0, 16'h0012, 0);
        chk("t1_addr", aram[0], 16'h0012);
        chk("t1_wren", {31'd0, wren[0]}, 0);
        idle(5);
        chk("t1_rdata0", rd0[0], 16'h00AB);
        // write then read of the same address from the other port
        access(0, 1, 16'h0001, 16'h1234);
        chk("t3_wren_hi", {31'd0, wren[0]}, 1);
        access(1, 0, 16'h0001, 0);
        chk("t3_wren_lo", {31'd0, wren[0]}, 0);
        idle(5);
        chk("t3_rdata1", rd1[0], 16'h1234);
        // both ports held: strict alternation starting with port 0
        req0 = 1; we0 = 0; addr0 = 16'h0020;
        req1 = 1; we1 = 0; addr1 = 16'h0030;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("t2_gnt0_%0d", i), {31'd0, gnt0[0]}, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("t2_gnt1_%0d", i), {31'd0, gnt1[0]}, (i % 2 == 1) ? 1 : 0);
        end
        @(posedge clock);
        #1 req0 = 0; req1 = 0;
        idle(6);
        // lock: port 1 held off until lock0 has dropped
        req1 = 1; we1 = 0; addr1 = 16'h0030;
        req0 = 1; we0 = 0; addr0 = 16'h0020; lock0 = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("t4_lock_gnt0_%0d", i), {31'd0, gnt0[0]}, 1);
            chk($sformatf("t4_lock_gnt1_%0d", i), {31'd0, gnt1[0]}, 0);
        end
        @(posedge clock);
        #1 req0 = 0; lock0 = 0;
        @(negedge clock);
        chk("t4_gnt1_drop_cycle", {31'd0, gnt1[0]}, 0);
        @(negedge clock);
        chk("t4_gnt1_after", {31'd0, gnt1[0]}, 1);
        @(posedge clock);
        #1 req1 = 0;
        idle(6);
        // reset with reads in flight and a write on the RAM bus
        access(0, 0, 16'h0020, 0);
        access(1, 0, 16'h0030, 0);
        access(0, 1, 16'h0040, 16'h7777);
        chk("t5_wren_pre", {31'd0, wren[0]}, 1);
        reset_n = 0;
        sb0.delete();
        sb1.delete();
        #1;
        chk("t5_wren_async", {30'd0, wren}, 0);
        chk("t5_addr_async", aram[0], 0);
        @(posedge clock);
        #1 reset_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk($sformatf("t5_no_rvalid_%0d", i), {28'd0, rv1, rv0}, 0);
        end
        @(posedge clock);
        #1;
        req0 = 1; we0 = 0; addr0 = 16'h0012;
        req1 = 1; we1 = 0; addr1 = 16'h0030;
        @(negedge clock);
        chk("t5_tie_gnt0", {31'd0, gnt0[0]}, 1);
        @(posedge clock);
        #1 req0 = 0; req1 = 0;
        idle(6);
        // back-to-back alternating reads for both latency builds
        for (int i = 0; i < 6; i++) access(i[0], 0, 16'h0050 + 16'(i), 0);
        idle(8);
        chk("drain_a", sb0.size(), 0);
        chk("drain_b", sb1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: port 0 is the stack-machine core and port 1 is the I/O/debug engine (switch/key capture, 7-segment refresh, dump).
- Accepts one access per cycle, drives the RAM address, write-data and write-enable lines from registers, and routes returned read data back to the issuing port.
- Round-robin arbitration, with an optional lock on port 0 for atomic read-modify-write sequences.

Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 16, RAM data width
- READ_LATENCY, 2, clock edges from a registered address_ram to valid q_ram (1..4)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request; held until gnt0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- lock0  in  1  port 0 keeps ownership while asserted
- gnt0  out  1  port 0 accepted this cycle (combinational)
- rvalid0  out  1  port 0 read data valid, one-cycle pulse
- rdata0  out  DATA_W  port 0 read data
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0 for port 1 (no lock)
- address_ram  out  ADDR_W  RAM address (registered)
- data_ram  out  DATA_W  RAM write data (registered)
- wren_ram  out  1  RAM write enable (registered)
- q_ram  in  DATA_W  RAM read data

Behaviour:
- Reset (asynchronous, reset_n=0):
  - address_ram, data_ram, rdata0 and rdata1 = 0.
  - wren_ram, rvalid0 and rvalid1 = 0.
  - last_grant = 1, so port 0 wins the first tie.
  - lock_owner = 0 and the tag pipeline is cleared.
- Handshake:
  - A port raises reqN with weN, addrN and wdataN stable.
  - The access is accepted in the cycle where gntN=1. The port may change its request fields in the following cycle.
  - A request that is not granted must stay asserted with unchanged fields.
- Arbitration (combinational, at most one grant per cycle):
  - If lock_owner=1 (port 0 holds the lock): gnt0=req0 and gnt1=0.
  - Otherwise, with only one request pending, that port is granted.
  - With both requests pending, the port other than last_grant is granted.
  - With no request, no grant.
- last_grant updates on every grant.
- Lock:
  - lock_owner is set on the edge ending a cycle with gnt0 && lock0.
  - It is cleared on the first edge where lock0=0, taking effect in the next cycle.
  - While port 0 holds the lock, port 1 waits indefinitely. There is no starvation timeout.
- Issue (edge ending a grant cycle t): address_ram<=addrN, data_ram<=wdataN, wren_ram<=weN.
- With no grant in a cycle:
  - wren_ram<=0.
  - address_ram and data_ram hold their previous values.
- Read return:
  - Each read grant pushes tag {valid, port} into a shift pipeline of READ_LATENCY+1 stages. Writes push valid=0.
  - At the tail, rdataN<=q_ram and rvalidN pulses in cycle t+READ_LATENCY+1. Default latency is 3 cycles after the grant.
  - The non-addressed port's rvalid stays 0 and its rdata holds its last value.
  - Back-to-back reads from alternating ports return in grant order, one per cycle, with no gaps or bubbles.
- Read-after-write to the same address in consecutive grants returns the new data. The RAM is write-first; the arbiter adds no forwarding.
- Reset mid-operation:
  - In-flight tags are discarded and no rvalid is produced for them.
  - wren_ram drops immediately (asynchronous reset).
- Width: addresses and data pass through unmodified. There is no arithmetic apart from the tag shift.

Decomposition:
- Shared package ram_arb_pkg:
  - the port_id_t typedef (1 bit),
  - the tag struct {valid, port_id},
  - the RAM_ADDR_W and RAM_DATA_W constants, also used by the core and the I/O engine.
- One sub-module, ram_arb_tag_pipe: a parameterised READ_LATENCY+1 tag shift register with asynchronous clear.
- The arbitration logic and the lock FSM (IDLE_RR, LOCKED) stay in the top module.

Test Plan:
- Reset released, port 0 read of 0x0012, where the RAM holds 0x00AB. Required: gnt0 in the same cycle; address_ram=0x0012 and wren_ram=0 after 1 edge; rvalid0=1 with rdata0=0x00AB 3 cycles after the grant; rvalid1 stays 0.
- req0 and req1 both held for 4 cycles, both reads. Required: grants go 0,1,0,1; rvalid pulses follow the same order with correct data per port.
- Port 0 writes 0x1234 to 0x0001, then port 1 reads 0x0001 the next cycle. Required: wren_ram=1 for exactly one cycle; rdata1=0x1234.
- Port 0 asserts lock0 over 3 accesses while req1 is held continuously. Required: gnt1=0 throughout the lock; gnt1=1 in the first cycle after lock0 drops.
- Two reads in flight, then reset_n pulsed low for one cycle. Required: wren_ram=0 immediately; no rvalid0 or rvalid1 after release; the next tie grants port 0.
- READ_LATENCY=1 build, alternating reads. Required: rvalid arrives 2 cycles after each grant, in order.
